// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU.
// Round-robin grant, registered operands, one-cycle ack pulse per operation.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [2:0]       op0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [2:0]       op1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic             last_grant_reg;
  logic             grant_reg;
  logic             illegal_reg;
  logic [1:0]       req_vec;
  logic [1:0]       legal_vec;
  logic [2:0]       op_vec [2];
  logic [WIDTH-1:0] a_vec  [2];
  logic [WIDTH-1:0] b_vec  [2];
  logic             grant_sel;
  logic             load_ops;
  logic             capture;

  assign req_vec   = {req1, req0};
  assign op_vec[0] = op0;
  assign op_vec[1] = op1;
  assign a_vec[0]  = a0;
  assign a_vec[1]  = a1;
  assign b_vec[0]  = b0;
  assign b_vec[1]  = b1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_legal
      assign legal_vec[gi] = (op_vec[gi] == 3'b000) || (op_vec[gi] == 3'b001) ||
                             (op_vec[gi] == 3'b010) || (op_vec[gi] == 3'b110) ||
                             (op_vec[gi] == 3'b111);
    end
  endgenerate

  // On a tie, favour whoever did not win last time.
  always_comb begin
    grant_sel = 1'b0;
    if (req_vec == 2'b11)
      grant_sel = ~last_grant_reg;
    else
      grant_sel = req_vec[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req_vec) state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    load_ops = 1'b0;
    capture  = 1'b0;
    case (state_reg)
      IDLE:    load_ops = |req_vec;
      EXEC: begin
        busy    = 1'b1;
        capture = 1'b1;
      end
      DONE:    busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      illegal_reg    <= 1'b0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_control    <= 3'b000;
    end else if (load_ops) begin
      last_grant_reg <= grant_sel;
      grant_reg      <= grant_sel;
      illegal_reg    <= ~legal_vec[grant_sel];
      alu_a          <= a_vec[grant_sel];
      alu_b          <= b_vec[grant_sel];
      // Illegal codes still run the ALU as ADD; the result is overridden at capture.
      alu_control    <= legal_vec[grant_sel] ? op_vec[grant_sel] : 3'b010;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err    <= 1'b0;
    end else if (capture) begin
      result <= illegal_reg ? '0 : alu_result;
      zero   <= illegal_reg ? 1'b1 : alu_zero;
      ack0   <= ~grant_reg;
      ack1   <= grant_reg;
      err    <= illegal_reg;
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, scoreboard of expected acks,
// scenario tasks run in sequence.
module tb_alu_arbiter;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic [2:0]       op0, op1;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             ack0, ack1;
  logic [WIDTH-1:0] result;
  logic             zero, err, busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] res;
    logic             z;
    logic             e;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .op0(op0),
    .a1(a1), .b1(b1), .op1(op1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .ack0(ack0), .ack1(ack1),
    .result(result), .zero(zero), .err(err), .busy(busy)
  );

  // Shared ALU model
  always_comb begin
    alu_result = '0;
    case (alu_control)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = alu_a + alu_b;
      3'b110:  alu_result = alu_a - alu_b;
      3'b111:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 1 : 0;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  // Scoreboard monitor: every ack pops one expected transaction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack0 && ack1) begin
        checks++;
        errors++;
        $display("FAIL ack_overlap: ack0=%0b ack1=%0b, required at most one", ack0, ack1);
      end else if (ack0 || ack1) begin
        exp_t x;
        int   got_id;
        got_id = ack1 ? 1 : 0;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_ack: ack%0d seen, no transaction expected", got_id);
        end else begin
          x = sb.pop_front();
          if (got_id !== x.id || result !== x.res || zero !== x.z || err !== x.e) begin
            errors++;
            $display("FAIL sb_txn: got id=%0d result=%0d zero=%0b err=%0b, required id=%0d result=%0d zero=%0b err=%0b",
                     got_id, result, zero, err, x.id, x.res, x.z, x.e);
          end else begin
            $display("txn ack%0d result=%0d zero=%0b err=%0b ok", got_id, result, zero, err);
          end
        end
      end
    end
  end

  // Caller is at a negedge with the DUT idle; returns negedges until ack (or -1).
  task automatic run_op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] op, input logic [WIDTH-1:0] er, input logic ez,
                        input logic ee, output int lat);
    exp_t x;
    x.id = id; x.res = er; x.z = ez; x.e = ee;
    sb.push_back(x);
    if (id == 0) begin a0 = a; b0 = b; op0 = op; req0 = 1'b1; end
    else         begin a1 = a; b1 = b; op1 = op; req1 = 1'b1; end
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if ((id == 0) ? ack0 : ack1) begin
        lat = c;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: no ack%0d within 12 cycles, required one", id);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0; a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({alu_a, alu_b, alu_control, result, zero, ack0, ack1, err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_state: alu_a=%0d alu_b=%0d ctl=%0b result=%0d zero=%0b ack=%0b%0b err=%0b busy=%0b, required all 0",
               alu_a, alu_b, alu_control, result, zero, ack1, ack0, err, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_add();
    int lat;
    exp_t x;
    x.id = 0; x.res = 17; x.z = 0; x.e = 0;
    sb.push_back(x);
    a0 = 10; b0 = 7; op0 = 3'b010; req0 = 1'b1;
    @(negedge clk);
    checks++;
    if (alu_control !== 3'b010 || alu_a !== 10 || alu_b !== 7 || busy !== 1'b1 || ack0 !== 1'b0) begin
      errors++;
      $display("FAIL add_exec: ctl=%0b a=%0d b=%0d busy=%0b ack0=%0b, required 010/10/7/1/0",
               alu_control, alu_a, alu_b, busy, ack0);
    end
    @(negedge clk);
    lat = ack0 ? 2 : -1;
    req0 = 1'b0;
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL add_latency: ack0=%0b two cycles after sample, required 1", ack0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (alu_a !== 10 || alu_b !== 7 || result !== 17 || busy !== 1'b0 || ack0 !== 1'b0) begin
      errors++;
      $display("FAIL add_hold: a=%0d b=%0d result=%0d busy=%0b ack0=%0b, required 10/7/17/0/0",
               alu_a, alu_b, result, busy, ack0);
    end
  endtask

  task automatic test_sweep();
    logic [2:0]       ops  [4] = '{3'b110, 3'b000, 3'b001, 3'b111};
    logic [WIDTH-1:0] ress [4] = '{32'd3, 32'd2, 32'd15, 32'd0};
    logic             zs   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(0, 10, 7, ops[i], ress[i], zs[i], 1'b0, lat);
      checks++;
      if (lat != 2) begin
        errors++;
        $display("FAIL sweep_latency op=%0b: %0d cycles, required 2", ops[i], lat);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    int lat;
    exp_t x;
    x.id = 1; x.res = 0; x.z = 1; x.e = 1;
    sb.push_back(x);
    a1 = 5; b1 = 9; op1 = 3'b011; req1 = 1'b1;
    @(negedge clk);
    checks++;
    if (alu_control !== 3'b010 || alu_a !== 5 || alu_b !== 9) begin
      errors++;
      $display("FAIL illegal_exec: ctl=%0b a=%0d b=%0d, required 010/5/9", alu_control, alu_a, alu_b);
    end
    lat = -1;
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      if (ack1) begin lat = c; break; end
    end
    req1 = 1'b0;
    checks++;
    if (lat != 2 || err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_ack: latency=%0d err=%0b, required 2 and 1", lat, err);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int   n = 0;
    int   t [3];
    exp_t x;
    x.id = 0; x.res = 17; x.z = 0; x.e = 0; sb.push_back(x);
    x.id = 1; x.res = 15; x.z = 0; x.e = 0; sb.push_back(x);
    x.id = 0; x.res = 17; x.z = 0; x.e = 0; sb.push_back(x);
    a0 = 10; b0 = 7; op0 = 3'b010;
    a1 = 20; b1 = 5; op1 = 3'b110;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        t[n] = c;
        n++;
        if (n == 3) break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (n != 3 || t[1] - t[0] != 3 || t[2] - t[1] != 3) begin
      errors++;
      $display("FAIL rr_spacing: %0d acks, gaps %0d/%0d, required 3 acks gaps 3/3",
               n, (n > 1) ? t[1] - t[0] : 0, (n > 2) ? t[2] - t[1] : 0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    int lat;
    exp_t x;
    a0 = 1; b0 = 2; op0 = 3'b010; req0 = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || alu_a !== 1) begin
      errors++;
      $display("FAIL rst_pre: busy=%0b a=%0d, required 1/1", busy, alu_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({alu_a, alu_b, alu_control, result, zero, ack0, ack1, err, busy} !== '0) begin
      errors++;
      $display("FAIL rst_async: a=%0d b=%0d ctl=%0b result=%0d zero=%0b ack=%0b%0b err=%0b busy=%0b, required all 0",
               alu_a, alu_b, alu_control, result, zero, ack1, ack0, err, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    x.id = 0; x.res = 3; x.z = 0; x.e = 0;
    sb.push_back(x);
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ack0) begin lat = c; break; end
    end
    req0 = 1'b0;
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL rst_regrant: ack0 latency %0d after release, required 2", lat);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_sweep();
    test_illegal();
    test_back_to_back();
    test_reset_mid_exec();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d transactions never acked, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
